// File: rtl/seq_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_timing_gen_pkg
//  Description : Shared CPU timing definitions: default counter geometry,
//                named timing-state indices, step-command encoding and the
//                count-to-one-hot decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_timing_gen_pkg;

    // Default geometry of the step counter and instruction-cycle counter
    localparam int c_cnt_w_default = 3;
    localparam int c_num_t_default = 8;
    localparam int c_cyc_w_default = 16;

    // Timing-state indices used by the timing-qualified decode logic
    localparam int T0_IDX = 0;
    localparam int T1_IDX = 1;
    localparam int T2_IDX = 2;
    localparam int T3_IDX = 3;
    localparam int T4_IDX = 4;
    localparam int T5_IDX = 5;
    localparam int T6_IDX = 6;
    localparam int T7_IDX = 7;

    // Resolved per-edge action of the step counter after priority selection
    typedef enum logic [2:0] {
        CMD_HOLD     = 3'd0,
        CMD_CLEAR    = 3'd1,
        CMD_LOAD     = 3'd2,
        CMD_LOAD_ERR = 3'd3,
        CMD_INC      = 3'd4,
        CMD_WRAP     = 3'd5
    } step_cmd_e;

    // Count-to-one-hot decode at the default geometry
    function automatic logic [c_num_t_default-1:0] count_to_onehot(
        input logic [c_cnt_w_default-1:0] count
    );
        logic [c_num_t_default-1:0] v;
        v        = '0;
        v[count] = 1'b1;
        return v;
    endfunction

endpackage : seq_timing_gen_pkg
`default_nettype wire

// File: rtl/seq_timing_gen_onehot_dec.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_dec
//  Description : Combinational binary-to-one-hot decoder, CNT_W -> NUM_T.
//                Indices >= NUM_T produce an all-zero vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_dec
    import seq_timing_gen_pkg::*;
#(
    parameter int CNT_W = c_cnt_w_default,
    parameter int NUM_T = c_num_t_default
) (
    input  logic [CNT_W-1:0] i_idx,
    output logic [NUM_T-1:0] o_onehot
);

    // One comparator per timing state
    for (genvar k = 0; k < NUM_T; k++) begin : g_bit
        assign o_onehot[k] = (i_idx == CNT_W'(k));
    end

endmodule : onehot_dec
`default_nettype wire

// File: rtl/seq_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : seq_timing_gen
//  Description : Instruction timing generator. Step counter with clear, load,
//                advance and wrap; registered one-hot timing bus T0..T(N-1);
//                wrap / illegal-load pulses; saturating count of completed
//                instruction cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_timing_gen
    import seq_timing_gen_pkg::*;
#(
    parameter int CNT_W = c_cnt_w_default,
    parameter int NUM_T = c_num_t_default,
    parameter int CYC_W = c_cyc_w_default
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rstsc,
    input  logic             inc,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    output logic [CNT_W-1:0] DATA_out,
    output logic [NUM_T-1:0] t_onehot,
    output logic             t_last,
    output logic             wrap,
    output logic             ld_err,
    output logic [CYC_W-1:0] cycles
);

    // NUM_T extended by one bit so NUM_T == 2**CNT_W still compares correctly
    localparam logic [CNT_W:0]   c_num_t_ext = (CNT_W+1)'(NUM_T);
    localparam logic [CNT_W-1:0] c_last      = CNT_W'(NUM_T-1);

    step_cmd_e        w_cmd;
    logic [CNT_W-1:0] w_cnt_d;
    logic [NUM_T-1:0] w_onehot_d;
    logic             w_wrap_d;
    logic             w_ld_err_d;
    logic             w_cyc_bump;
    logic [CYC_W-1:0] w_cycles_d;

    logic [CNT_W-1:0] r_cnt_q;
    logic [NUM_T-1:0] r_onehot_q;
    logic             r_wrap_q;
    logic             r_ld_err_q;
    logic [CYC_W-1:0] r_cycles_q;

    // Resolve control inputs into one action: rstsc > ld > inc > hold
    always_comb begin
        w_cmd = CMD_HOLD;
        if (rstsc) begin
            w_cmd = CMD_CLEAR;
        end else if (ld) begin
            w_cmd = ({1'b0, ld_val} < c_num_t_ext) ? CMD_LOAD : CMD_LOAD_ERR;
        end else if (inc) begin
            w_cmd = (r_cnt_q == c_last) ? CMD_WRAP : CMD_INC;
        end
    end

    // Next-state values for count, pulses and cycle counter
    always_comb begin
        w_cnt_d    = r_cnt_q;
        w_wrap_d   = 1'b0;
        w_ld_err_d = 1'b0;
        w_cyc_bump = 1'b0;
        case (w_cmd)
            CMD_CLEAR: begin
                w_cnt_d    = '0;
                w_cyc_bump = 1'b1;
            end
            CMD_LOAD:     w_cnt_d    = ld_val;
            CMD_LOAD_ERR: w_ld_err_d = 1'b1;
            CMD_INC:      w_cnt_d    = r_cnt_q + 1'b1;
            CMD_WRAP: begin
                w_cnt_d    = '0;
                w_wrap_d   = 1'b1;
                w_cyc_bump = 1'b1;
            end
            default: begin
                w_cnt_d = r_cnt_q;
            end
        endcase
        // Saturate at all-ones rather than rolling over
        w_cycles_d = (w_cyc_bump && (r_cycles_q != '1)) ? r_cycles_q + 1'b1
                                                        : r_cycles_q;
    end

    // Decode the next count so the registered timing bus lines up with DATA_out
    onehot_dec #(
        .CNT_W (CNT_W),
        .NUM_T (NUM_T)
    ) u_onehot_dec (
        .i_idx    (w_cnt_d),
        .o_onehot (w_onehot_d)
    );

    // State registers with synchronous reset to T0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q    <= '0;
            r_onehot_q <= NUM_T'(1);
            r_wrap_q   <= 1'b0;
            r_ld_err_q <= 1'b0;
            r_cycles_q <= '0;
        end else begin
            r_cnt_q    <= w_cnt_d;
            r_onehot_q <= w_onehot_d;
            r_wrap_q   <= w_wrap_d;
            r_ld_err_q <= w_ld_err_d;
            r_cycles_q <= w_cycles_d;
        end
    end

    assign DATA_out = r_cnt_q;
    assign t_onehot = r_onehot_q;
    assign t_last   = (r_cnt_q == c_last);
    assign wrap     = r_wrap_q;
    assign ld_err   = r_ld_err_q;
    assign cycles   = r_cycles_q;

endmodule : seq_timing_gen
`default_nettype wire

// File: tb/tb_seq_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_timing_gen
//  Description : Self-checking bench for seq_timing_gen. Two instances share
//                one stimulus stream: A at default geometry (8 states, 16-bit
//                cycles) and B with 6 states and a 2-bit cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_timing_gen;

    localparam int c_nt_a  = 8;
    localparam int c_cyc_a = 16;
    localparam int c_nt_b  = 6;
    localparam int c_cyc_b = 2;

    typedef struct {
        int cnt;
        int oh;
        int last;
        int wrp;
        int err;
        int cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rstsc;
    logic       inc;
    logic       ld;
    logic [2:0] ld_val;

    logic [2:0]        data_a;
    logic [c_nt_a-1:0] oh_a;
    logic              last_a, wrap_a, err_a;
    logic [c_cyc_a-1:0] cyc_a;

    logic [2:0]        data_b;
    logic [c_nt_b-1:0] oh_b;
    logic              last_b, wrap_b, err_b;
    logic [c_cyc_b-1:0] cyc_b;

    int n_err;
    int n_checks;

    exp_t q_a[$];
    exp_t q_b[$];

    // Reference model state
    int m_cnt_a, m_cyc_a, m_cnt_b, m_cyc_b;

    seq_timing_gen #(.CNT_W(3), .NUM_T(c_nt_a), .CYC_W(c_cyc_a)) dut_a (
        .clk(clk), .rst(rst), .rstsc(rstsc), .inc(inc), .ld(ld), .ld_val(ld_val),
        .DATA_out(data_a), .t_onehot(oh_a), .t_last(last_a), .wrap(wrap_a),
        .ld_err(err_a), .cycles(cyc_a)
    );

    seq_timing_gen #(.CNT_W(3), .NUM_T(c_nt_b), .CYC_W(c_cyc_b)) dut_b (
        .clk(clk), .rst(rst), .rstsc(rstsc), .inc(inc), .ld(ld), .ld_val(ld_val),
        .DATA_out(data_b), .t_onehot(oh_b), .t_last(last_b), .wrap(wrap_b),
        .ld_err(err_b), .cycles(cyc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural rules of one clock edge, for a counter of nt states
    task automatic model(input int nt, input int cmax, inout int cnt, inout int cyc,
                         output exp_t e);
        e.wrp = 0;
        e.err = 0;
        if (rst) begin
            cnt = 0;
            cyc = 0;
        end else if (rstsc) begin
            cnt = 0;
            if (cyc < cmax) cyc = cyc + 1;
        end else if (ld) begin
            if (int'(ld_val) < nt) cnt = int'(ld_val);
            else e.err = 1;
        end else if (inc) begin
            if (cnt + 1 == nt) begin
                cnt   = 0;
                e.wrp = 1;
                if (cyc < cmax) cyc = cyc + 1;
            end else begin
                cnt = cnt + 1;
            end
        end
        e.cnt  = cnt;
        e.oh   = 1 << cnt;
        e.last = (cnt == nt - 1) ? 1 : 0;
        e.cyc  = cyc;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one set of inputs, predict the outcome, queue it once the edge occurs
    task automatic step(input bit r, input bit rs, input bit l, input int lv, input bit in);
        exp_t ea, eb;
        rst    = r;
        rstsc  = rs;
        ld     = l;
        ld_val = 3'(lv);
        inc    = in;
        model(c_nt_a, (1 << c_cyc_a) - 1, m_cnt_a, m_cyc_a, ea);
        model(c_nt_b, (1 << c_cyc_b) - 1, m_cnt_b, m_cyc_b, eb);
        @(posedge clk);
        q_a.push_back(ea);
        q_b.push_back(eb);
        #1;
    endtask

    exp_t mon_a;
    exp_t mon_b;

    // Monitor for instance A
    always @(negedge clk) begin
        if (q_a.size() > 0) begin
            mon_a = q_a.pop_front();
            chk("a_data",   int'(data_a), mon_a.cnt);
            chk("a_onehot", int'(oh_a),   mon_a.oh);
            chk("a_t_last", int'(last_a), mon_a.last);
            chk("a_wrap",   int'(wrap_a), mon_a.wrp);
            chk("a_ld_err", int'(err_a),  mon_a.err);
            chk("a_cycles", int'(cyc_a),  mon_a.cyc);
        end
    end

    // Monitor for instance B
    always @(negedge clk) begin
        if (q_b.size() > 0) begin
            mon_b = q_b.pop_front();
            chk("b_data",   int'(data_b), mon_b.cnt);
            chk("b_onehot", int'(oh_b),   mon_b.oh);
            chk("b_t_last", int'(last_b), mon_b.last);
            chk("b_wrap",   int'(wrap_b), mon_b.wrp);
            chk("b_ld_err", int'(err_b),  mon_b.err);
            chk("b_cycles", int'(cyc_b),  mon_b.cyc);
        end
    end

    initial begin
        n_err    = 0;
        n_checks = 0;
        m_cnt_a  = 0;
        m_cyc_a  = 0;
        m_cnt_b  = 0;
        m_cyc_b  = 0;
        rst = 1'b1; rstsc = 1'b0; inc = 1'b0; ld = 1'b0; ld_val = '0;
        @(posedge clk);
        #1;

        // Reset for two clocks
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Free-running advance across the wrap point
        repeat (9) step(0, 0, 0, 0, 1);

        // Clear beats advance at count 3
        step(0, 1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);

        // Illegal then legal load, inc ignored on the illegal edge for B
        step(0, 0, 1, 7, 1);
        step(0, 0, 1, 5, 0);
        step(0, 0, 0, 0, 0);

        // Hold at 4, then reset overrides advance
        step(0, 0, 1, 4, 0);
        repeat (5) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);

        // Back-to-back clears drive the narrow cycle counter into saturation
        repeat (4) step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            int p;
            p = int'($urandom_range(0, 99));
            step(p < 2, (p >= 2) && (p < 12), (p >= 12) && (p < 30),
                 int'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7));
        end
        step(0, 0, 0, 0, 0);

        // Drain: everything queued must have been checked within two cycles
        repeat (2) @(negedge clk);
        #1;
        chk("drain_a", q_a.size(), 0);
        chk("drain_b", q_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_seq_timing_gen
`default_nettype wire
